train_seq: RTL and testbench
============================

TRAIN_SEQ -- requirements
Module: train_seq

Interface
REQ-001 SHALL provide parameter ADDR_WIDTH, default 12, RAM address / data-point count width.
REQ-002 SHALL provide parameter MAX_FEATURES, default 15, largest legal feat value.
REQ-003 SHALL provide parameter HOLD_CYCLES, default 8, RAM writeback window length in cycles (>=1).
REQ-004 SHALL provide parameter WDOG_WIDTH, default 24, watchdog and run-cycle counter width.
REQ-005 SHALL provide ports: CLK in 1 clock; RST in 1 synchronous active-high reset; the block has one clock, and reset is synchronous and active-high.
REQ-006 SHALL provide ports: start in 1 launch pulse; abort in 1 cancel request; feat in 4 feature count; data_points in ADDR_WIDTH data-point count.
REQ-007 SHALL provide ports: ser_done in 1; ser_we_stop in 1; sgd_done in 1; ser_addr in ADDR_WIDTH; sgd_addr in ADDR_WIDTH.
REQ-008 SHALL provide ports: addr out ADDR_WIDTH; ser_rst, ram_rst, ram_we, ram_oe, sgd_rst, sgd_hold out 1 each.
REQ-009 SHALL provide ports: busy out 1; done_ out 1; err out 1; err_code out 2; run_cycles out WDOG_WIDTH.

Function
REQ-010 SHALL implement registered-state FSM IDLE, SER_IN, SGD, FLUSH, DONE, ERR; all state transitions on rising CLK.
REQ-011 IDLE: ser_rst=ram_rst=sgd_rst=1, ram_we=ram_oe=0; start=1 with legal config -> SER_IN next cycle; illegal config (feat>MAX_FEATURES or data_points==0) -> ERR, err_code=1.
REQ-012 SER_IN: ser_rst=ram_rst=0, sgd_rst=1, ram_oe=0, ram_we=!ser_we_stop (combinational); ser_done=1 -> SGD next cycle, with ram_we forced 0 in that cycle.
REQ-013 SGD: all sub-block resets 0, ram_oe=1, ram_we=0; sgd_done=1 -> FLUSH next cycle.
REQ-014 FLUSH: ram_we=1, ram_oe=0, sgd_hold=1 for exactly HOLD_CYCLES cycles, then DONE.
REQ-015 DONE: sgd_hold=1, ram_we=ram_oe=0, done_=1; held until RST or start.
REQ-016 ERR: err=1, all sub-block resets 1, ram_we=ram_oe=0; err_code held until RST or start.
REQ-017 start in DONE or ERR SHALL clear done_/err/err_code/run_cycles and re-run REQ-011 validation (relaunch); start in SER_IN/SGD/FLUSH SHALL be ignored.
REQ-018 abort=1 in SER_IN, SGD or FLUSH -> ERR, err_code=2, next cycle; abort has priority over ser_done, sgd_done and watchdog in the same cycle; abort ignored in IDLE/DONE/ERR.
REQ-019 addr SHALL equal sgd_addr in SGD and FLUSH, ser_addr in all other states (combinational mux).
REQ-020 busy=1 exactly in SER_IN, SGD, FLUSH.
REQ-021 run_cycles SHALL clear on launch, increment each busy cycle, saturate at all-ones, freeze in DONE/ERR.
REQ-022 ser_done/sgd_done outside their own state SHALL be ignored.

Reset
REQ-023 RST=1 at a clock edge SHALL force IDLE from any state, including mid-SER_IN/SGD/FLUSH, and clear done_, err, err_code, run_cycles, watchdog, hold counter.
REQ-024 Output values during and after reset SHALL be the IDLE values: ser_rst=ram_rst=sgd_rst=1, all others 0, addr=ser_addr.

Configuration
REQ-025 Macro TRAIN_SEQ_WDOG_EN defined: WDOG_WIDTH-bit watchdog clears on entry to SER_IN and to SGD, increments each cycle there; reaching all-ones -> ERR, err_code=3 next cycle.
REQ-026 Macro TRAIN_SEQ_WDOG_EN undefined: no watchdog logic; SER_IN/SGD wait indefinitely; err_code=3 never produced.

Verification
REQ-027 Nominal: feat=3, data_points=4, start pulse, ser_done after 10 cycles, sgd_done after 20 -> FLUSH 8 cycles with ram_we=1, DONE, done_=1, run_cycles=39.
REQ-028 Illegal config: feat=15 with MAX_FEATURES=7, start -> ERR next cycle, err_code=1, busy never 1.
REQ-029 Abort race: in SGD drive abort=1 and sgd_done=1 same cycle -> ERR, err_code=2, sgd_hold never 1.
REQ-030 Watchdog: TRAIN_SEQ_WDOG_EN defined, WDOG_WIDTH=4, ser_done never asserted -> ERR with err_code=3 exactly 15 cycles after SER_IN entry.
REQ-031 Mid-run reset: RST=1 in FLUSH cycle 3 -> IDLE next cycle, ram_we=0, done_=0, run_cycles=0; later start completes nominal run.
REQ-032 Relaunch and mux: start in DONE -> SER_IN, addr tracks ser_addr; in SGD addr tracks sgd_addr; ser_we_stop=1 in SER_IN -> ram_we=0 same cycle.

Source files
------------

// File: rtl/train_seq.sv
`default_nettype none
// ============================================================================
// Module   : train_seq  -- serial load -> SGD -> RAM writeback sequencer
// Options  : TRAIN_SEQ_WDOG_EN enables the SER_IN/SGD watchdog
// Revision : 1.0 - initial release
// ============================================================================
module train_seq #(
  parameter int ADDR_WIDTH   = 12,
  parameter int MAX_FEATURES = 15,
  parameter int HOLD_CYCLES  = 8,
  parameter int WDOG_WIDTH   = 24
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic                  abort,
  input  logic [3:0]            feat,
  input  logic [ADDR_WIDTH-1:0] data_points,
  input  logic                  ser_done,
  input  logic                  ser_we_stop,
  input  logic                  sgd_done,
  input  logic [ADDR_WIDTH-1:0] ser_addr,
  input  logic [ADDR_WIDTH-1:0] sgd_addr,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  ser_rst,
  output logic                  ram_rst,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic                  sgd_rst,
  output logic                  sgd_hold,
  output logic                  busy,
  output logic                  done_,
  output logic                  err,
  output logic [1:0]            err_code,
  output logic [WDOG_WIDTH-1:0] run_cycles
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SER_IN = 3'd1,
    S_SGD    = 3'd2,
    S_FLUSH  = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  localparam logic [4:0]            c_MAX_FEAT  = 5'(MAX_FEATURES);
  localparam int                    c_HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [c_HOLD_W-1:0]   c_HOLD_LAST = c_HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [c_HOLD_W-1:0]   c_HOLD_ONE  = c_HOLD_W'(1);
  localparam logic [WDOG_WIDTH-1:0] c_CNT_MAX   = '1;
  localparam logic [WDOG_WIDTH-1:0] c_CNT_ONE   = WDOG_WIDTH'(1);

  state_t                r_state;
  state_t                w_next;
  logic [c_HOLD_W-1:0]   r_hold_cnt;
  logic [WDOG_WIDTH-1:0] r_run_cycles;
  logic [1:0]            r_err_code;
  logic [1:0]            w_err_code_nxt;
  logic                  w_launch;
  logic                  w_cfg_ok;
  logic                  w_busy;
  logic                  w_wdog_trip;

  assign w_cfg_ok = ({1'b0, feat} <= c_MAX_FEAT) && (data_points != '0);
  assign w_launch = start && (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR);
  assign w_busy   = (r_state == S_SER_IN) || (r_state == S_SGD) || (r_state == S_FLUSH);

`ifdef TRAIN_SEQ_WDOG_EN
  localparam logic [WDOG_WIDTH-1:0] c_WDOG_LAST = c_CNT_MAX - c_CNT_ONE;
  logic [WDOG_WIDTH-1:0] r_wdog;

  // Restarts on every state change, so it times SER_IN and SGD separately.
  always_ff @(posedge CLK) begin
    if (RST || (w_next != r_state)) begin
      r_wdog <= '0;
    end else if (r_state == S_SER_IN || r_state == S_SGD) begin
      r_wdog <= r_wdog + c_CNT_ONE;
    end
  end

  assign w_wdog_trip = (r_state == S_SER_IN || r_state == S_SGD) && (r_wdog == c_WDOG_LAST);
`else
  assign w_wdog_trip = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_err_code <= 2'd0;
    end else begin
      r_state    <= w_next;
      r_err_code <= w_err_code_nxt;
    end
  end

  always_comb begin
    w_next         = r_state;
    w_err_code_nxt = r_err_code;
    ser_rst        = 1'b1;
    ram_rst        = 1'b1;
    sgd_rst        = 1'b1;
    ram_we         = 1'b0;
    ram_oe         = 1'b0;
    sgd_hold       = 1'b0;
    done_          = 1'b0;
    err            = 1'b0;
    case (r_state)
      S_IDLE: w_next = S_IDLE;
      S_SER_IN: begin
        ser_rst = 1'b0;
        ram_rst = 1'b0;
        ram_we  = !ser_we_stop && !ser_done;
        if (abort) begin
          w_next = S_ERR;  w_err_code_nxt = 2'd2;
        end else if (ser_done) begin
          w_next = S_SGD;
        end else if (w_wdog_trip) begin
          w_next = S_ERR;  w_err_code_nxt = 2'd3;
        end
      end
      S_SGD: begin
        ser_rst = 1'b0;
        ram_rst = 1'b0;
        sgd_rst = 1'b0;
        ram_oe  = 1'b1;
        if (abort) begin
          w_next = S_ERR;  w_err_code_nxt = 2'd2;
        end else if (sgd_done) begin
          w_next = S_FLUSH;
        end else if (w_wdog_trip) begin
          w_next = S_ERR;  w_err_code_nxt = 2'd3;
        end
      end
      S_FLUSH: begin
        ser_rst  = 1'b0;
        ram_rst  = 1'b0;
        sgd_rst  = 1'b0;
        ram_we   = 1'b1;
        sgd_hold = 1'b1;
        if (abort) begin
          w_next = S_ERR;  w_err_code_nxt = 2'd2;
        end else if (r_hold_cnt == c_HOLD_LAST) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        ser_rst  = 1'b0;
        ram_rst  = 1'b0;
        sgd_rst  = 1'b0;
        sgd_hold = 1'b1;
        done_    = 1'b1;
      end
      S_ERR:   err    = 1'b1;
      default: w_next = S_IDLE;
    endcase
    // A launch re-validates the configuration from any idle-like state.
    if (w_launch) begin
      w_next         = w_cfg_ok ? S_SER_IN : S_ERR;
      w_err_code_nxt = w_cfg_ok ? 2'd0 : 2'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || (r_state != S_FLUSH)) begin
      r_hold_cnt <= '0;
    end else begin
      r_hold_cnt <= r_hold_cnt + c_HOLD_ONE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || w_launch) begin
      r_run_cycles <= '0;
    end else if (w_busy && (r_run_cycles != c_CNT_MAX)) begin
      r_run_cycles <= r_run_cycles + c_CNT_ONE;
    end
  end

  assign addr       = (r_state == S_SGD || r_state == S_FLUSH) ? sgd_addr : ser_addr;
  assign busy       = w_busy;
  assign err_code   = r_err_code;
  assign run_cycles = r_run_cycles;

endmodule
`default_nettype wire

// File: tb/tb_train_seq.sv
`default_nettype none
// Module: tb_train_seq -- directed self-checking bench for train_seq.
module tb_train_seq;

  logic        CLK = 1'b0;
  logic        rst, start, abort, ser_done, ser_we_stop, sgd_done;
  logic [3:0]  feat;
  logic [11:0] data_points, ser_addr, sgd_addr;

  logic [11:0] addr;
  logic        ser_rst, ram_rst, ram_we, ram_oe, sgd_rst, sgd_hold, busy, done_, err;
  logic [1:0]  err_code;
  logic [23:0] run_cycles;

  logic [11:0] s_addr;
  logic        s_ser_rst, s_ram_rst, s_ram_we, s_ram_oe, s_sgd_rst, s_sgd_hold, s_busy, s_done, s_err;
  logic [1:0]  s_err_code;
  logic [3:0]  s_run_cycles;

  // {ser_rst,ram_rst,sgd_rst, ram_we,ram_oe,sgd_hold, busy,done_,err}
  logic [8:0] ctl, s_ctl;
  assign ctl   = {ser_rst, ram_rst, sgd_rst, ram_we, ram_oe, sgd_hold, busy, done_, err};
  assign s_ctl = {s_ser_rst, s_ram_rst, s_sgd_rst, s_ram_we, s_ram_oe, s_sgd_hold, s_busy, s_done, s_err};

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  train_seq #(.ADDR_WIDTH(12), .MAX_FEATURES(7), .HOLD_CYCLES(8), .WDOG_WIDTH(24)) u_dut (
    .CLK(CLK), .RST(rst), .start(start), .abort(abort), .feat(feat), .data_points(data_points),
    .ser_done(ser_done), .ser_we_stop(ser_we_stop), .sgd_done(sgd_done),
    .ser_addr(ser_addr), .sgd_addr(sgd_addr), .addr(addr),
    .ser_rst(ser_rst), .ram_rst(ram_rst), .ram_we(ram_we), .ram_oe(ram_oe),
    .sgd_rst(sgd_rst), .sgd_hold(sgd_hold), .busy(busy), .done_(done_), .err(err),
    .err_code(err_code), .run_cycles(run_cycles)
  );

  // Narrow counter instance: exercises saturation and the watchdog.
  train_seq #(.ADDR_WIDTH(12), .MAX_FEATURES(7), .HOLD_CYCLES(8), .WDOG_WIDTH(4)) u_dut_w4 (
    .CLK(CLK), .RST(rst), .start(start), .abort(abort), .feat(feat), .data_points(data_points),
    .ser_done(ser_done), .ser_we_stop(ser_we_stop), .sgd_done(sgd_done),
    .ser_addr(ser_addr), .sgd_addr(sgd_addr), .addr(s_addr),
    .ser_rst(s_ser_rst), .ram_rst(s_ram_rst), .ram_we(s_ram_we), .ram_oe(s_ram_oe),
    .sgd_rst(s_sgd_rst), .sgd_hold(s_sgd_hold), .busy(s_busy), .done_(s_done), .err(s_err),
    .err_code(s_err_code), .run_cycles(s_run_cycles)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_start(input logic [3:0] f, input logic [11:0] dp);
    feat = f; data_points = dp; start = 1'b1;
    tick();
    start = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; ser_done = 1'b0; ser_we_stop = 1'b0; sgd_done = 1'b0;
    feat = 4'd3; data_points = 12'd4; ser_addr = 12'h123; sgd_addr = 12'h456;
    tick(); tick();
    checks++; if (ctl !== 9'b111_000_000) begin errors++; $display("FAIL rst_ctl: got %b expected %b", ctl, 9'b111_000_000); end
    checks++; if (err_code !== 2'd0) begin errors++; $display("FAIL rst_err_code: got %0d expected 0", err_code); end
    checks++; if (run_cycles !== 24'd0) begin errors++; $display("FAIL rst_run_cycles: got %0d expected 0", run_cycles); end
    checks++; if (addr !== 12'h123) begin errors++; $display("FAIL rst_addr: got %h expected 123", addr); end
    checks++; if (s_ctl !== 9'b111_000_000) begin errors++; $display("FAIL rst_ctl_w4: got %b expected %b", s_ctl, 9'b111_000_000); end
    checks++; if (s_addr !== 12'h123) begin errors++; $display("FAIL rst_addr_w4: got %h expected 123", s_addr); end
    rst = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (ctl !== 9'b111_000_000) begin errors++; $display("FAIL idle_abort_ignored: got %b expected %b", ctl, 9'b111_000_000); end
  endtask

  task automatic test_nominal();
    do_start(4'd3, 12'd4);
    checks++; if (ctl !== 9'b001_100_100) begin errors++; $display("FAIL nom_ser_ctl: got %b expected %b", ctl, 9'b001_100_100); end
    checks++; if (run_cycles !== 24'd0) begin errors++; $display("FAIL nom_run_start: got %0d expected 0", run_cycles); end
    checks++; if (addr !== ser_addr) begin errors++; $display("FAIL nom_ser_addr: got %h expected %h", addr, ser_addr); end
    repeat (10) tick();
    ser_done = 1'b1; #1;
    checks++; if (ctl !== 9'b001_000_100) begin errors++; $display("FAIL nom_ser_done_we: got %b expected %b", ctl, 9'b001_000_100); end
    tick();
    ser_done = 1'b0; #1;
    checks++; if (ctl !== 9'b000_010_100) begin errors++; $display("FAIL nom_sgd_ctl: got %b expected %b", ctl, 9'b000_010_100); end
    checks++; if (run_cycles !== 24'd11) begin errors++; $display("FAIL nom_run_sgd: got %0d expected 11", run_cycles); end
    checks++; if (addr !== sgd_addr) begin errors++; $display("FAIL nom_sgd_addr: got %h expected %h", addr, sgd_addr); end
    repeat (19) tick();
    sgd_done = 1'b1;
    tick();
    sgd_done = 1'b0; #1;
    checks++; if (run_cycles !== 24'd31) begin errors++; $display("FAIL nom_run_flush: got %0d expected 31", run_cycles); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (ctl[5:0] !== 6'b101_100) begin errors++; $display("FAIL nom_flush cycle %0d: got %b expected %b", i + 1, ctl[5:0], 6'b101_100); end
      tick();
    end
    checks++; if (ctl[5:0] !== 6'b001_010) begin errors++; $display("FAIL nom_done_ctl: got %b expected %b", ctl[5:0], 6'b001_010); end
    checks++; if (run_cycles !== 24'd39) begin errors++; $display("FAIL nom_run_done: got %0d expected 39", run_cycles); end
    sgd_done = 1'b1; ser_done = 1'b1; abort = 1'b1;
    tick();
    sgd_done = 1'b0; ser_done = 1'b0; abort = 1'b0; #1;
    checks++; if (ctl[5:0] !== 6'b001_010) begin errors++; $display("FAIL nom_done_hold: got %b expected %b", ctl[5:0], 6'b001_010); end
    checks++; if (run_cycles !== 24'd39) begin errors++; $display("FAIL nom_run_frozen: got %0d expected 39", run_cycles); end
  endtask

  task automatic test_illegal();
    rst = 1'b1; tick(); rst = 1'b0;
    feat = 4'd15; data_points = 12'd4; start = 1'b1; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ill_busy_launch: got %b expected 0", busy); end
    tick();
    start = 1'b0; #1;
    checks++; if (ctl !== 9'b111_000_001) begin errors++; $display("FAIL ill_feat_ctl: got %b expected %b", ctl, 9'b111_000_001); end
    checks++; if (err_code !== 2'd1) begin errors++; $display("FAIL ill_feat_code: got %0d expected 1", err_code); end
    tick();
    checks++; if (err_code !== 2'd1 || busy !== 1'b0) begin errors++; $display("FAIL ill_hold: got code %0d busy %b expected code 1 busy 0", err_code, busy); end
    do_start(4'd7, 12'd1);
    checks++; if (ctl !== 9'b001_100_100 || err_code !== 2'd0) begin errors++; $display("FAIL ill_feat_max_ok: got %b code %0d expected %b code 0", ctl, err_code, 9'b001_100_100); end
    abort = 1'b1; tick(); abort = 1'b0; #1;
    checks++; if (ctl !== 9'b111_000_001 || err_code !== 2'd2) begin errors++; $display("FAIL abort_ser: got %b code %0d expected %b code 2", ctl, err_code, 9'b111_000_001); end
    do_start(4'd3, 12'd0);
    checks++; if (ctl !== 9'b111_000_001 || err_code !== 2'd1) begin errors++; $display("FAIL ill_dp_zero: got %b code %0d expected %b code 1", ctl, err_code, 9'b111_000_001); end
  endtask

  task automatic test_abort_race();
    do_start(4'd3, 12'd4);
    ser_done = 1'b1; tick(); ser_done = 1'b0; #1;
    checks++; if (ctl !== 9'b000_010_100) begin errors++; $display("FAIL race_sgd: got %b expected %b", ctl, 9'b000_010_100); end
    abort = 1'b1; sgd_done = 1'b1; #1;
    checks++; if (sgd_hold !== 1'b0) begin errors++; $display("FAIL race_hold_pre: got %b expected 0", sgd_hold); end
    tick();
    abort = 1'b0; sgd_done = 1'b0; #1;
    checks++; if (ctl !== 9'b111_000_001 || err_code !== 2'd2) begin errors++; $display("FAIL race_err: got %b code %0d expected %b code 2", ctl, err_code, 9'b111_000_001); end
    checks++; if (run_cycles !== 24'd2) begin errors++; $display("FAIL race_run: got %0d expected 2", run_cycles); end
    tick();
    checks++; if (sgd_hold !== 1'b0 || run_cycles !== 24'd2) begin errors++; $display("FAIL race_frozen: got hold %b run %0d expected hold 0 run 2", sgd_hold, run_cycles); end
  endtask

  task automatic test_midrun_reset();
    do_start(4'd3, 12'd4);
    ser_done = 1'b1; tick(); ser_done = 1'b0;
    sgd_done = 1'b1; tick(); sgd_done = 1'b0;
    tick(); tick();
    checks++; if (ctl[5:0] !== 6'b101_100) begin errors++; $display("FAIL mid_flush3: got %b expected %b", ctl[5:0], 6'b101_100); end
    rst = 1'b1; tick(); rst = 1'b0; #1;
    checks++; if (ctl !== 9'b111_000_000) begin errors++; $display("FAIL mid_idle: got %b expected %b", ctl, 9'b111_000_000); end
    checks++; if (run_cycles !== 24'd0) begin errors++; $display("FAIL mid_run: got %0d expected 0", run_cycles); end
    tick();
    checks++; if (ctl !== 9'b111_000_000) begin errors++; $display("FAIL mid_idle_stay: got %b expected %b", ctl, 9'b111_000_000); end
  endtask

  task automatic test_relaunch_mux();
    ser_addr = 12'hABC; sgd_addr = 12'h5A5; #1;
    checks++; if (addr !== 12'hABC) begin errors++; $display("FAIL mux_done: got %h expected abc", addr); end
    start = 1'b1; tick(); start = 1'b0; #1;
    checks++; if (ctl !== 9'b001_100_100 || run_cycles !== 24'd0) begin errors++; $display("FAIL rel_ser: got %b run %0d expected %b run 0", ctl, run_cycles, 9'b001_100_100); end
    ser_addr = 12'h001; #1;
    checks++; if (addr !== 12'h001) begin errors++; $display("FAIL mux_ser_track: got %h expected 001", addr); end
    ser_we_stop = 1'b1; #1;
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rel_we_stop: got %b expected 0", ram_we); end
    ser_we_stop = 1'b0; #1;
    checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL rel_we_resume: got %b expected 1", ram_we); end
    start = 1'b1; sgd_done = 1'b1; tick(); start = 1'b0; sgd_done = 1'b0; #1;
    checks++; if (ctl !== 9'b001_100_100 || run_cycles !== 24'd1) begin errors++; $display("FAIL rel_ser_ignore: got %b run %0d expected %b run 1", ctl, run_cycles, 9'b001_100_100); end
    ser_done = 1'b1; tick(); ser_done = 1'b0; #1;
    checks++; if (addr !== 12'h5A5) begin errors++; $display("FAIL mux_sgd: got %h expected 5a5", addr); end
    sgd_addr = 12'h0F0; #1;
    checks++; if (addr !== 12'h0F0) begin errors++; $display("FAIL mux_sgd_track: got %h expected 0f0", addr); end
    ser_done = 1'b1; start = 1'b1; tick(); ser_done = 1'b0; start = 1'b0; #1;
    checks++; if (ctl !== 9'b000_010_100 || run_cycles !== 24'd3) begin errors++; $display("FAIL rel_sgd_ignore: got %b run %0d expected %b run 3", ctl, run_cycles, 9'b000_010_100); end
    abort = 1'b1; tick(); abort = 1'b0; #1;
    checks++; if (err_code !== 2'd2 || addr !== 12'h001) begin errors++; $display("FAIL rel_abort_sgd: got code %0d addr %h expected code 2 addr 001", err_code, addr); end
  endtask

  task automatic test_wdog();
    rst = 1'b1; tick(); rst = 1'b0;
    do_start(4'd3, 12'd4);
    for (int i = 1; i < 15; i++) begin
      checks++; if (s_busy !== 1'b1) begin errors++; $display("FAIL wdog_wait cycle %0d: got busy %b expected 1", i, s_busy); end
      tick();
    end
    checks++; if (s_busy !== 1'b1) begin errors++; $display("FAIL wdog_wait cycle 15: got busy %b expected 1", s_busy); end
    tick();
`ifdef TRAIN_SEQ_WDOG_EN
    checks++; if (s_ctl !== 9'b111_000_001 || s_err_code !== 2'd3) begin errors++; $display("FAIL wdog_trip: got %b code %0d expected %b code 3", s_ctl, s_err_code, 9'b111_000_001); end
`else
    checks++; if (s_ctl !== 9'b001_100_100 || s_err_code !== 2'd0) begin errors++; $display("FAIL wdog_absent: got %b code %0d expected %b code 0", s_ctl, s_err_code, 9'b001_100_100); end
`endif
    repeat (5) tick();
    checks++; if (s_run_cycles !== 4'hF) begin errors++; $display("FAIL run_saturate: got %0d expected 15", s_run_cycles); end
    checks++; if (busy !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL wide_still_busy: got busy %b err %b expected busy 1 err 0", busy, err); end
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_illegal();
    test_abort_race();
    test_midrun_reset();
    test_nominal();
    test_relaunch_mux();
    test_wdog();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
